sd_cmd_sender: RTL and testbench
================================

SD_CMD_SENDER -- requirements
Module: sd_cmd_sender

Interface
REQ-001 SHALL have port clk  in  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port Start  in  1  command request; sampled only in IDLE.
REQ-004 SHALL have port CmdIndex  in  6  SD command index.
REQ-005 SHALL have port Argument  in  32  command argument.
REQ-006 SHALL have port BitStrobe  in  1  one-cycle tick per SD bit period; paces line output.
REQ-007 SHALL have port Busy  out  1  high from the cycle after Start acceptance until the Done cycle, inclusive.
REQ-008 SHALL have port Done  out  1  one-cycle pulse when the frame is complete.
REQ-009 SHALL have port CmdOut  out  1  CMD line data; idle value 1.
REQ-010 SHALL have port CmdOE  out  1  CMD line output enable.
REQ-011 SHALL have port CRC  out  7  CRC7 of the current/last frame; holds until next acceptance.

Function
REQ-012 SHALL implement states IDLE, CRC_CALC, SEND, DONE.
REQ-013 IDLE: Start=1 SHALL latch {1'b0, 1'b1, CmdIndex, Argument} as 40-bit header, clear the CRC register, and enter CRC_CALC.
REQ-014 CRC_CALC SHALL shift one header bit per clk, MSB first, through CRC7 (x^7+x^3+1, polynomial 0x09, init 0); after exactly 40 cycles it SHALL enter SEND; BitStrobe SHALL be ignored here.
REQ-015 SEND SHALL hold a 48-bit frame {header, CRC, 1'b1}; on each BitStrobe it SHALL drive the next bit, MSB first, on CmdOut with CmdOE=1; the first bit SHALL be driven on the first BitStrobe in SEND.
REQ-016 A 6-bit bit counter SHALL count driven bits; the BitStrobe after the 48th bit SHALL move to DONE, so the end bit is held for one full bit period.
REQ-017 DONE SHALL last exactly one cycle: Done=1, CmdOE=0, CmdOut=1; then IDLE.
REQ-018 Start during CRC_CALC, SEND or DONE SHALL be ignored, with no queuing.
REQ-019 Start and BitStrobe in the same IDLE cycle SHALL accept Start; that strobe SHALL drive no bit.
REQ-020 CmdIndex/Argument changes after acceptance SHALL not affect the frame in flight.
REQ-021 Request-to-Done latency SHALL be 1 + 40 cycles + 49 BitStrobe intervals (+1 DONE cycle).
REQ-022 Outside SEND, CmdOE SHALL be 0 and CmdOut SHALL be 1.

Reset
REQ-023 rst=1 SHALL force IDLE, Busy=0, Done=0, CmdOut=1, CmdOE=0, CRC=0 and bit counter=0 immediately, independent of clk.
REQ-024 Reset mid-CRC_CALC or mid-SEND SHALL abort the frame, produce no Done pulse, and release the line within the reset assertion.
REQ-025 After rst deasserts, the first clk edge SHALL be able to accept Start.

Structure
REQ-026 Package sd_pkg SHALL hold the state enum, CRC7_POLY=7'h09, FRAME_BITS=48, HEADER_BITS=40, and the start/transmission/end bit constants.
REQ-027 CRC7 SHALL be one sub-module, crc7_serial (ports: clk, rst, Clear, BitEn, BitIn, Crc[6:0]), with one bit per enabled clk.
REQ-028 CRC SHALL be computed serially; no lookup table.

Verification
REQ-029 CMD0, Argument=0 -> CRC=7'h4A; CmdOut sequence 0x40_00000000_95, MSB first; one Done pulse.
REQ-030 CMD8, Argument=32'h000001AA -> CRC=7'h43; frame 0x48_000001AA_87.
REQ-031 CMD17, Argument=0 -> CRC=7'h2A; frame 0x51_00000000_55; BitStrobe every 4 clk; Busy-to-Done = 40 + 49*4 cycles (±strobe phase).
REQ-032 Start pulsed each cycle during SEND of CMD0 -> exactly one frame, one Done; a second frame only after Start is re-asserted in IDLE.
REQ-033 rst asserted at bit 20 of SEND -> CmdOE=0 and CmdOut=1 asynchronously, no Done; the next CMD0 produces the correct 0x95 trailer.
REQ-034 Start coincident with BitStrobe in IDLE -> accepted; CmdOE stays 0 until the first BitStrobe in SEND.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared types and constants for the SD command-line transmitter.
// The state encoding is kept as a 2-bit enum so it matches legacy register dumps.
package sd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CRC_CALC = 2'd1,
    ST_SEND     = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  localparam logic [6:0] CRC7_POLY   = 7'h09;
  localparam int         FRAME_BITS  = 48;
  localparam int         HEADER_BITS = 40;

  localparam logic START_BIT = 1'b0;
  localparam logic TX_BIT    = 1'b1;
  localparam logic END_BIT   = 1'b1;

  localparam logic [5:0] LAST_HEADER_IDX = 6'(HEADER_BITS - 1);
  localparam logic [5:0] LAST_FRAME_IDX  = 6'(FRAME_BITS - 1);
  localparam logic [5:0] FRAME_BITS_CNT  = 6'(FRAME_BITS);

endpackage

// File: rtl/crc7_serial.sv
// Bit-serial CRC7 (x^7 + x^3 + 1), one message bit per enabled clock, MSB first.
module crc7_serial
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       Clear,
  input  logic       BitEn,
  input  logic       BitIn,
  output logic [6:0] Crc
);

  logic feedback;

  assign feedback = BitIn ^ Crc[6];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Crc <= '0;
    end else if (Clear) begin
      Crc <= '0;
    end else if (BitEn) begin
      Crc <= {Crc[5:0], 1'b0} ^ (feedback ? CRC7_POLY : 7'h00);
    end
  end

endmodule

// File: rtl/sd_cmd_sender.sv
// SD CMD-line transmitter: latches a command, computes its CRC7 serially,
// then shifts the 48-bit frame out paced by BitStrobe.
module sd_cmd_sender
  import sd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        Start,
  input  logic [5:0]  CmdIndex,
  input  logic [31:0] Argument,
  input  logic        BitStrobe,
  output logic        Busy,
  output logic        Done,
  output logic        CmdOut,
  output logic        CmdOE,
  output logic [6:0]  CRC
);

  state_t      state;
  logic [39:0] header;
  logic [5:0]  bit_cnt;
  logic        cmd_bit;
  logic        line_en;
  logic        accept;
  logic        crc_en;
  logic        crc_bit;
  logic [47:0] frame;

  assign accept  = (state == ST_IDLE) && Start;
  assign crc_en  = (state == ST_CRC_CALC);
  assign crc_bit = header[LAST_HEADER_IDX - bit_cnt];
  assign frame   = {header, CRC, END_BIT};

  crc7_serial u_crc (
    .clk   (clk),
    .rst   (rst),
    .Clear (accept),
    .BitEn (crc_en),
    .BitIn (crc_bit),
    .Crc   (CRC)
  );

  // bit_cnt indexes header bits during CRC_CALC and counts driven bits in SEND.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      header  <= '0;
      bit_cnt <= '0;
      cmd_bit <= 1'b1;
      line_en <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start) begin
            header  <= {START_BIT, TX_BIT, CmdIndex, Argument};
            bit_cnt <= '0;
            state   <= ST_CRC_CALC;
          end
        end
        ST_CRC_CALC: begin
          if (bit_cnt == LAST_HEADER_IDX) begin
            bit_cnt <= '0;
            state   <= ST_SEND;
          end else begin
            bit_cnt <= bit_cnt + 6'd1;
          end
        end
        ST_SEND: begin
          if (BitStrobe) begin
            if (bit_cnt == FRAME_BITS_CNT) begin
              // End bit has been held for a full bit period; release the line.
              state   <= ST_DONE;
              line_en <= 1'b0;
              cmd_bit <= 1'b1;
            end else begin
              cmd_bit <= frame[LAST_FRAME_IDX - bit_cnt];
              line_en <= 1'b1;
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
        end
        ST_DONE: begin
          bit_cnt <= '0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign Busy   = (state != ST_IDLE);
  assign Done   = (state == ST_DONE);
  assign CmdOE  = line_en && (state == ST_SEND);
  assign CmdOut = CmdOE ? cmd_bit : 1'b1;

endmodule

// File: tb/tb_sd_cmd_sender.sv
// Directed self-checking bench for sd_cmd_sender: known SD frames, pacing,
// Start filtering, coincident strobe and mid-frame reset abort.
module tb_sd_cmd_sender;

  logic        clk;
  logic        rst;
  logic        Start;
  logic [5:0]  CmdIndex;
  logic [31:0] Argument;
  logic        BitStrobe;
  logic        Busy;
  logic        Done;
  logic        CmdOut;
  logic        CmdOE;
  logic [6:0]  CRC;

  sd_cmd_sender dut (
    .clk       (clk),
    .rst       (rst),
    .Start     (Start),
    .CmdIndex  (CmdIndex),
    .Argument  (Argument),
    .BitStrobe (BitStrobe),
    .Busy      (Busy),
    .Done      (Done),
    .CmdOut    (CmdOut),
    .CmdOE     (CmdOE),
    .CRC       (CRC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Per-frame observations filled by run_frame.
  logic [47:0] got;
  int          nbits;
  int          done_cnt;
  int          done_c;
  int          busy_first;
  int          oe_cycles;
  int          abort_c;
  logic        busy_c1;
  logic        busy_at_done;
  logic        busy_after;
  logic [6:0]  crc_at_done;
  logic        aborted;
  logic        prev_strobe;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge: drives Start there, then per cycle samples outputs at
  // the negedge and drives the next inputs.
  task automatic run_frame(input logic [5:0] idx, input logic [31:0] arg, input int period,
                           input bit spam, input bit coincide, input int abort_at);
    got = '0; nbits = 0; done_cnt = 0; done_c = -1; busy_first = -1; oe_cycles = 0;
    abort_c = 0; busy_c1 = 1'b0; busy_at_done = 1'b0; busy_after = 1'b1;
    crc_at_done = '0; aborted = 1'b0; prev_strobe = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (prev_strobe && CmdOE) begin
          got = {got[46:0], CmdOut};
          nbits++;
        end
        if (CmdOE) oe_cycles++;
        if (Busy && busy_first < 0) busy_first = c;
        if (c == 1) busy_c1 = Busy;
        if (Done) begin
          done_cnt++;
          if (done_c < 0) begin
            done_c = c;
            busy_at_done = Busy;
            crc_at_done = CRC;
          end
        end
        if (done_c >= 0 && c == done_c + 1) busy_after = Busy;
      end
      if (abort_at > 0 && !aborted && nbits == abort_at) begin
        #2 rst = 1'b1;
        #1;
        check("abort_oe",   64'(CmdOE),  64'd0);
        check("abort_out",  64'(CmdOut), 64'd1);
        check("abort_busy", 64'(Busy),   64'd0);
        check("abort_crc",  64'(CRC),    64'd0);
        @(negedge clk);
        rst = 1'b0;
        aborted = 1'b1;
        abort_c = c;
      end
      if ((done_c >= 0 && c >= done_c + 6) || (aborted && c >= abort_c + 80)) break;
      Start     = (c == 0) || (spam && done_cnt == 0 && !aborted);
      CmdIndex  = (c == 0) ? idx : ~idx;
      Argument  = (c == 0) ? arg : ~arg;
      BitStrobe = (coincide && c == 0) || (c % period == period - 1);
      prev_strobe = BitStrobe;
    end
    Start = 1'b0;
    BitStrobe = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [47:0] exp_frame,
                             input logic [6:0] exp_crc, input int period);
    check({tag, "_nbits"},     64'(nbits),        64'd48);
    check({tag, "_frame"},     64'(got),          64'(exp_frame));
    check({tag, "_crc"},       64'(crc_at_done),  64'(exp_crc));
    check({tag, "_done_cnt"},  64'(done_cnt),     64'd1);
    check({tag, "_busy_c1"},   64'(busy_c1),      64'd1);
    check({tag, "_busy_done"}, 64'(busy_at_done), 64'd1);
    check({tag, "_busy_idle"}, 64'(busy_after),   64'd0);
    check({tag, "_oe_cycles"}, 64'(oe_cycles),    64'(48 * period));
    check({tag, "_crc_hold"},  64'(CRC),          64'(exp_crc));
    check({tag, "_idle_line"}, 64'({CmdOE, CmdOut}), 64'b01);
  endtask

  initial begin
    rst = 1'b1; Start = 1'b0; CmdIndex = '0; Argument = '0; BitStrobe = 1'b0;
    #1;
    check("rst_busy", 64'(Busy),   64'd0);
    check("rst_done", 64'(Done),   64'd0);
    check("rst_out",  64'(CmdOut), 64'd1);
    check("rst_oe",   64'(CmdOE),  64'd0);
    check("rst_crc",  64'(CRC),    64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_frame(6'd0, 32'h0, 2, 1'b0, 1'b0, 0);
    check_frame("cmd0", 48'h40_0000_0000_95, 7'h4A, 2);

    @(negedge clk);
    run_frame(6'd8, 32'h0000_01AA, 3, 1'b0, 1'b0, 0);
    check_frame("cmd8", 48'h48_0000_01AA_87, 7'h43, 3);

    @(negedge clk);
    run_frame(6'd17, 32'h0, 4, 1'b0, 1'b0, 0);
    check_frame("cmd17", 48'h51_0000_0000_55, 7'h2A, 4);
    check("cmd17_latency", 64'(done_c - busy_first), 64'd235);

    @(negedge clk);
    run_frame(6'd0, 32'h0, 2, 1'b1, 1'b0, 0);
    check_frame("spam", 48'h40_0000_0000_95, 7'h4A, 2);

    @(negedge clk);
    run_frame(6'd0, 32'h0, 3, 1'b0, 1'b1, 0);
    check_frame("coincide", 48'h40_0000_0000_95, 7'h4A, 3);

    @(negedge clk);
    run_frame(6'd0, 32'h0, 2, 1'b0, 1'b0, 20);
    check("abort_seen",    64'(aborted),  64'd1);
    check("abort_no_done", 64'(done_cnt), 64'd0);
    check("abort_idle",    64'(Busy),     64'd0);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_frame(6'd0, 32'h0, 2, 1'b0, 1'b0, 0);
    check_frame("post_rst", 48'h40_0000_0000_95, 7'h4A, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
